axi4_burst_read_engine: RTL and testbench

//  Parametrised AXI4 read master. Takes one linear read request (addr, beat count) and splits it into

---
 rtl/axi4_burst_read_engine.sv | 133 +++++++++++++
 tb/tb_axi4_burst_read_engine.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_read_engine.sv
// AXI4 read master: splits one linear read request into INCR bursts that respect
// MAX_BURST and 4 KB page limits, and streams returned beats out with a request-level last.
module axi4_burst_read_engine #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 512,
   parameter int ID_W      = 4,
   parameter int ARID_VAL  = 0,
   parameter int MAX_BURST = 16,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [CNT_W-1:0]  req_beats,
   output logic [ADDR_W-1:0] araddr,
   output logic [7:0]        arlen,
   output logic [2:0]        arsize,
   output logic [1:0]        arburst,
   output logic [ID_W-1:0]   arid,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rlast,
   input  logic [ID_W-1:0]   rid,
   input  logic              rvalid,
   output logic              rready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              done,
   output logic              err
);
   localparam int BYTES = DATA_W / 8;
   localparam int SIZE  = $clog2(BYTES);
   localparam int CW    = (CNT_W > 13) ? CNT_W : 13;

   typedef enum logic [2:0] {IDLE, CALC, ADDR, DATA, DONE} state_t;
   state_t state;

   logic [ADDR_W-1:0] addr;
   logic [CNT_W-1:0]  remaining;
   logic [8:0]        burst;
   logic [8:0]        beat_cnt;
   logic [12:0]       page_bytes;
   logic [CW-1:0]     burst_calc;
   logic              beat_fire;
   logic              last_of_burst;
   logic              rid_unused;

   // Only one burst is ever outstanding, so the returned ID carries no information.
   assign rid_unused = ^rid;

   assign page_bytes = 13'h1000 - {1'b0, addr[11:0]};

   always_comb begin
      burst_calc = CW'(remaining);
      if (burst_calc > CW'(MAX_BURST))
         burst_calc = CW'(MAX_BURST);
      if (burst_calc > CW'(page_bytes >> SIZE))
         burst_calc = CW'(page_bytes >> SIZE);
   end

   assign arsize        = 3'(SIZE);
   assign arburst       = 2'b01;
   assign arid          = ID_W'(ARID_VAL);
   assign rready        = (state == DATA) && out_ready;
   assign out_valid     = (state == DATA) && rvalid;
   assign out_data      = rdata;
   assign out_last      = out_valid && (remaining == CNT_W'(1));
   assign beat_fire     = rvalid && rready;
   assign last_of_burst = (beat_cnt == 9'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         arvalid   <= 1'b0;
         araddr    <= '0;
         arlen     <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         addr      <= '0;
         remaining <= '0;
         burst     <= '0;
         beat_cnt  <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (req_valid) begin
               addr      <= {req_addr[ADDR_W-1:SIZE], {SIZE{1'b0}}};
               remaining <= req_beats;
               err       <= 1'b0;
               req_ready <= 1'b0;
               state     <= (req_beats == '0) ? DONE : CALC;
            end
            CALC: begin
               burst   <= burst_calc[8:0];
               araddr  <= addr;
               arlen   <= 8'(burst_calc - CW'(1));
               arvalid <= 1'b1;
               state   <= ADDR;
            end
            ADDR: if (arready) begin
               arvalid  <= 1'b0;
               beat_cnt <= burst;
               state    <= DATA;
            end
            // Beat counting follows beat_cnt; a wrong rlast only flags the error.
            DATA: if (beat_fire) begin
               beat_cnt  <= beat_cnt - 9'd1;
               remaining <= remaining - CNT_W'(1);
               if ((rresp != 2'b00) || (rlast != last_of_burst))
                  err <= 1'b1;
               if (last_of_burst) begin
                  addr  <= addr + (ADDR_W'(burst) << SIZE);
                  state <= (remaining == CNT_W'(1)) ? DONE : CALC;
               end
            end
            DONE: begin
               done      <= 1'b1;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_burst_read_engine.sv
// Bench for axi4_burst_read_engine: AXI slave and stream sink agents, a linear-address
// reference model, directed vector table, reset-in-flight sequence and randomized requests.
module tb_axi4_burst_read_engine;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 512;
   localparam int ID_W   = 4;
   localparam int CNT_W  = 16;
   localparam int BYTES  = DATA_W / 8;
   localparam int W      = DATA_W;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              req_valid, req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [CNT_W-1:0]  req_beats;
   logic [ADDR_W-1:0] araddr;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic [ID_W-1:0]   arid;
   logic              arvalid, arready;
   logic [DATA_W-1:0] rdata;
   logic [1:0]        rresp;
   logic              rlast;
   logic [ID_W-1:0]   rid;
   logic              rvalid, rready;
   logic [DATA_W-1:0] out_data;
   logic              out_last, out_valid, out_ready;
   logic              done, err;

   axi4_burst_read_engine #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .ARID_VAL(0), .MAX_BURST(16), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_beats(req_beats),
      .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arid(arid),
      .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rlast(rlast), .rid(rid), .rvalid(rvalid), .rready(rready),
      .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cycle = 0;

   // agent configuration
   int omode;
   bit ar_rand, r_rand;
   int resp_beat, last_beat;

   // agent state and recorders
   bit          req_pend, r_active, r_hold, prev_ar_wait;
   logic [31:0] r_addr, prev_araddr;
   logic [7:0]  prev_arlen;
   int          r_len, r_idx, r_gidx;
   logic [39:0]       got_ar[$];
   logic [DATA_W-1:0] got_data[$];
   bit                got_last[$];
   int   n_done, done_cycle, accept_cycle;
   logic done_err;

   typedef struct {
      logic [31:0] addr;
      int          beats;
      int          om;
      int          rb;
      int          lb;
      int          n_ar;
      logic [31:0] ar0_addr;
      int          ar0_len;
      logic [31:0] arn_addr;
      int          arn_len;
      bit          want_err;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   function automatic logic [DATA_W-1:0] pattern(input logic [31:0] a);
      logic [DATA_W-1:0] d;
      for (int k = 0; k < DATA_W / 32; k++)
         d[k*32 +: 32] = a ^ (32'h9E3779B9 * 32'(k + 1));
      return d;
   endfunction

   task automatic agents_clear();
      req_pend = 0; r_active = 0; r_hold = 0; prev_ar_wait = 0;
      r_idx = 0; r_len = 0; r_gidx = 0; r_addr = '0;
   endtask

   // One clock of slave, sink and request driver; sampling sits 2 units after the negedge.
   task automatic step();
      @(negedge clk);
      req_valid = req_pend;
      arready   = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      rid       = 4'($urandom);
      if (r_active) begin
         if (!r_hold) rvalid = r_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         rdata = pattern(r_addr + 32'(r_idx * BYTES));
         rlast = ((r_idx == r_len) != (r_gidx == last_beat));
         rresp = (r_gidx == resp_beat) ? 2'b10 : 2'b00;
      end else begin
         rvalid = 1'b0;
         rlast  = 1'b0;
         rresp  = 2'b00;
      end
      case (omode)
         0:       out_ready = 1'b1;
         1:       out_ready = (cycle % 2 == 0);
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #2;
      if (prev_ar_wait)
         chk("ar_stable", W'({arvalid, araddr, arlen}), W'({1'b1, prev_araddr, prev_arlen}));
      prev_ar_wait = arvalid && !arready;
      prev_araddr  = araddr;
      prev_arlen   = arlen;
      if (arvalid && arready) begin
         chk("arsize", W'(arsize), W'(6));
         chk("arburst_arid", W'({arburst, arid}), W'({2'b01, 4'h0}));
         got_ar.push_back({araddr, arlen});
         r_active = 1; r_addr = araddr; r_len = int'(arlen); r_idx = 0;
      end
      if (out_valid && out_ready) begin
         got_data.push_back(out_data);
         got_last.push_back(out_last);
      end
      r_hold = rvalid && !rready;
      if (rvalid && rready) begin
         r_idx++; r_gidx++;
         if (r_idx > r_len) r_active = 0;
      end
      if (accept_cycle >= 0 && cycle == accept_cycle + 1)
         chk("busy_req_ready", W'(req_ready), W'(0));
      if (done) begin
         n_done++;
         done_cycle = cycle;
         done_err   = err;
      end
      if (req_valid && req_ready) begin
         req_pend     = 0;
         accept_cycle = cycle;
      end
      cycle++;
   endtask

   task automatic start_req(input logic [31:0] a, input int beats);
      req_addr  = a;
      req_beats = CNT_W'(beats);
      req_pend  = 1;
      r_gidx    = 0;
      n_done    = 0;
      done_err  = 1'b0;
      accept_cycle = -1;
      done_cycle   = -1;
      got_ar.delete();
      got_data.delete();
      got_last.delete();
   endtask

   task automatic run_req(input logic [31:0] a, input int beats, input int om, input bit arr,
                          input bit rr, input int rb, input int lb);
      logic [39:0] want_ar[$];
      logic [31:0] base, ma;
      int rem, room, b, budget, c, n;
      bit want_err;
      omode = om; ar_rand = arr; r_rand = rr; resp_beat = rb; last_beat = lb;
      start_req(a, beats);
      budget = 200 + beats * 24;
      c = 0;
      while (n_done == 0 && c < budget) begin
         step();
         c++;
      end
      if (n_done == 0) chk("done_timeout", W'(0), W'(1));

      // reference: linear address walk split at 16 beats and 4 KB pages
      base = a & ~32'h3F;
      ma   = base;
      rem  = beats;
      while (rem > 0) begin
         room = (4096 - int'(ma % 4096)) / BYTES;
         b = rem;
         if (b > 16) b = 16;
         if (b > room) b = room;
         want_ar.push_back({ma, 8'(b - 1)});
         ma  = ma + 32'(b * BYTES);
         rem = rem - b;
      end
      want_err = (rb >= 0 && rb < beats) || (lb >= 0 && lb < beats);

      chk("n_ar", W'(got_ar.size()), W'(want_ar.size()));
      n = (got_ar.size() < want_ar.size()) ? got_ar.size() : want_ar.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("ar[%0d]", i), W'(got_ar[i]), W'(want_ar[i]));
      chk("n_beats", W'(got_data.size()), W'(beats));
      n = (got_data.size() < beats) ? got_data.size() : beats;
      for (int i = 0; i < n; i++) begin
         chk($sformatf("data[%0d]", i), got_data[i], pattern(base + 32'(i * BYTES)));
         chk($sformatf("last[%0d]", i), W'(got_last[i]), W'(i == beats - 1));
      end
      chk("err_at_done", W'(done_err), W'(want_err));
      repeat (3) step();
      chk("done_once", W'(n_done), W'(1));
      chk("idle_req_ready", W'(req_ready), W'(1));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 0; req_valid = 0; req_addr = '0; req_beats = '0; arready = 0;
      rvalid = 0; rdata = '0; rresp = 2'b00; rlast = 0; rid = '0; out_ready = 0;
      omode = 0; ar_rand = 0; r_rand = 0; resp_beat = -1; last_beat = -1;
      n_done = 0; done_cycle = -1; accept_cycle = -1; done_err = 0;
      agents_clear();
      repeat (3) @(negedge clk);
      #2;
      chk("rst_ctrl", W'({req_ready, arvalid, rready, out_valid, done, err}), W'(6'b100000));
      chk("rst_ar", W'({araddr, arlen}), W'(0));
      @(negedge clk);
      rst_n = 1;

      //            addr          beats om  rb  lb  nar ar0_addr      len0 arn_addr      lenN err
      vecs[0] = '{32'h0000_1000, 16, 0, -1, -1, 1, 32'h0000_1000, 15, 32'h0000_1000, 15, 0};
      vecs[1] = '{32'h0000_0F80, 10, 0, -1, -1, 2, 32'h0000_0F80,  1, 32'h0000_1000,  7, 0};
      vecs[2] = '{32'h0000_0000, 40, 0, -1, -1, 3, 32'h0000_0000, 15, 32'h0000_0800,  7, 0};
      vecs[3] = '{32'h0000_2000,  4, 1,  1, -1, 1, 32'h0000_2000,  3, 32'h0000_2000,  3, 1};
      vecs[4] = '{32'h0000_3000,  4, 0, -1,  2, 1, 32'h0000_3000,  3, 32'h0000_3000,  3, 1};
      vecs[5] = '{32'h0000_0040,  0, 0, -1, -1, 0, 32'h0000_0000,  0, 32'h0000_0000,  0, 0};
      vecs[6] = '{32'h0000_1007,  3, 2, -1, -1, 1, 32'h0000_1000,  2, 32'h0000_1000,  2, 0};
      vecs[7] = '{32'hFFFF_FFC0,  3, 0, -1, -1, 2, 32'hFFFF_FFC0,  0, 32'h0000_0000,  1, 0};

      for (int i = 0; i < 8; i++) begin
         run_req(vecs[i].addr, vecs[i].beats, vecs[i].om, 0, 0, vecs[i].rb, vecs[i].lb);
         chk($sformatf("tbl%0d_n_ar", i), W'(got_ar.size()), W'(vecs[i].n_ar));
         chk($sformatf("tbl%0d_err", i), W'(done_err), W'(vecs[i].want_err));
         if (vecs[i].n_ar > 0 && got_ar.size() > 0) begin
            chk($sformatf("tbl%0d_ar0", i), W'(got_ar[0]),
                W'({vecs[i].ar0_addr, 8'(vecs[i].ar0_len)}));
            chk($sformatf("tbl%0d_arn", i), W'(got_ar[got_ar.size() - 1]),
                W'({vecs[i].arn_addr, 8'(vecs[i].arn_len)}));
         end
         if (vecs[i].n_ar == 3 && got_ar.size() == 3)
            chk($sformatf("tbl%0d_ar1", i), W'(got_ar[1]), W'({32'h0000_0400, 8'd15}));
         if (vecs[i].beats == 0)
            chk("zero_done_latency", W'(done_cycle - accept_cycle), W'(2));
      end

      // reset while the second burst of a 40-beat request is streaming
      omode = 0; ar_rand = 0; r_rand = 0; resp_beat = -1; last_beat = -1;
      start_req(32'h0000_0000, 40);
      for (int c = 0; c < 400 && got_data.size() < 18; c++) step();
      chk("rst_reach_burst2", W'(got_ar.size() == 2 && got_data.size() >= 18), W'(1));
      @(negedge clk);
      rst_n = 0; rvalid = 0; req_valid = 0;
      #2;
      chk("midrst_ctrl", W'({req_ready, arvalid, rready, out_valid, done, err}), W'(6'b100000));
      chk("midrst_ar", W'({araddr, arlen}), W'(0));
      repeat (2) @(negedge clk);
      rst_n = 1;
      agents_clear();
      accept_cycle = -1;
      run_req(32'h0000_1000, 16, 0, 0, 0, -1, -1);

      // randomized requests against the reference model
      for (int i = 0; i < 30; i++) begin
         logic [31:0] a;
         int bt, rb, lb;
         a = $urandom;
         if ($urandom_range(0, 2) == 0) a[11:0] = 12'hE00 | 12'($urandom_range(0, 511));
         if ($urandom_range(0, 7) == 0) a[31:12] = 20'hFFFFF;
         bt = int'($urandom_range(0, 48));
         rb = (bt > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, bt - 1)) : -1;
         lb = (bt > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, bt - 1)) : -1;
         run_req(a, bt, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), rb, lb);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
